// File: rtl/hs_rx_fifo_if.sv
// Handshake bundle between the synchronizer/consumer side and hs_rx_fifo.
// master: the environment (push strobe + consumer ready); slave: the FIFO.
interface hs_rx_fifo_if #(
  parameter int WIDTH = 32
);
  logic             dvalid;
  logic [WIDTH-1:0] dout;
  logic             dbusy;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output dvalid, dout, out_ready,
    input  dbusy, out_valid, out_data
  );

  modport slave (
    input  dvalid, dout, out_ready,
    output dbusy, out_valid, out_data
  );
endinterface

// File: rtl/hs_rx_fifo.sv
// hs_rx_fifo: destination-side receive buffer downstream of the handshake
// synchronizer. Captures single-cycle dvalid/dout words into a circular buffer
// and presents them first-word-fall-through on a valid/ready interface.
// dbusy asserts at DEPTH-1 entries so in-flight words always find a slot.
// Optional feature macro: HS_RX_OVF_CNT_EN (8-bit saturating drop counter).
module hs_rx_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          dclk,
  input  logic          rst_n,
  hs_rx_fifo_if.slave   bus,
  input  logic          flush,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic [7:0]    ovf_cnt
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] BUSY_LVL = (AW+1)'(DEPTH - 1);

  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic push, pop, full, push_ok, drop;

  assign push    = bus.dvalid;
  assign pop     = bus.out_valid & bus.out_ready;
  assign full    = (cnt_q == FULL_LVL);
  // A full FIFO still takes a word if the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);
  assign drop    = push & ~push_ok;

  assign bus.out_valid = (cnt_q != '0);
  assign bus.out_data  = mem_q[rp_q];
  assign bus.dbusy     = (cnt_q >= BUSY_LVL);
  assign level         = cnt_q;
  assign ovf           = ovf_q;

  // Next-state for pointers, occupancy and sticky overflow; flush wins over traffic.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (push_ok) wp_d = wp_q + 1'b1;
      if (pop)     rp_d = rp_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (drop) ovf_d = 1'b1;
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // One register per entry; cleared on reset so out_data reads zero afterwards.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      logic we;
      assign we = push_ok & ~flush & (wp_q == AW'(gi));
      // Capture the pushed word into this slot when the write pointer selects it.
      always_ff @(posedge dclk) begin
        if (!rst_n)  mem_q[gi] <= '0;
        else if (we) mem_q[gi] <= bus.dout;
      end
    end
  endgenerate

`ifdef HS_RX_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating count of dropped words, cleared by flush.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (flush)                          ovf_cnt_d = 8'd0;
    else if (drop && ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  // Drop counter register.
  always_ff @(posedge dclk) begin
    if (!rst_n) ovf_cnt_q <= 8'd0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = 8'd0;
`endif

endmodule
